ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage LoongArch pipeline, directly downstream of the decode stage. It latches the 161-bit decode bus and computes the instruction result: single-cycle ALU ops, single-cycle 32×32 multiply, and an iterative 33-cycle divider. It issues the data-SRAM request for loads and stores. It returns forwarding and stall information to decode and forwards a 75-bit bus to the memory stage.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset; one clock, sampled on posedge clk
- ID_to_EX_Valid  in  1  decode holds a valid instruction for EX
- ID_to_EX_Bus  in  161  fields:
  - [160] mem_is_byte, [159] mem_is_half, [158] src_is_signed, [157] inst_ld_w
  - [156:141] alu_op (one-hot), [140:109] pc, [108:77] imm, [76:45] rj_value, [44:13] rkd_value
  - [12] src1_is_pc, [11] src2_is_imm, [10] res_from_mem, [9] gr_we, [8:5] mem_we, [4:0] dest
- EX_Allow_in  out  1  EX can accept an instruction this cycle
- ME_Allow_in  in  1  memory stage can accept
- EX_to_ME_Valid  out  1  EX hands a finished instruction to ME
- EX_to_ME_Bus  out  75  fields:
  - [74:71] bus[160:157], [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] pc, [31:0] ex_result
- EX_dest  out  5  dest if EX_Valid && gr_we, else 0
- EX_Forward_Res  out  32  ex_result (combinational)
- EX_to_ID_Ld_op  out  1  EX result not forwardable: EX_Valid && (res_from_mem || divider op not yet in DONE)
- data_sram_en  out  1  data SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  lane-replicated store data

## Operation
- Pipeline register and EX_Valid:
  - Load bus and EX_Valid <= 1 when ID_to_EX_Valid && EX_Allow_in.
  - EX_Valid <= 0 when EX_Allow_in && !ID_to_EX_Valid.
  - Otherwise hold.
- EX_ReadyGo = !is_div || div_state==DONE, where is_div = alu_op[14]|alu_op[15].
- EX_Allow_in = !EX_Valid || (EX_ReadyGo && ME_Allow_in); EX_to_ME_Valid = EX_Valid && EX_ReadyGo.
- Operands: src1 = src1_is_pc ? pc : rj_value; src2 = src2_is_imm ? imm : rkd_value.
- alu_op[11:0] go to the team's existing 12-op `alu` module (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
- alu_op[12]: result = low 32 bits of src1*src2.
- alu_op[13]: result = high 32 bits of the 64-bit product; operands sign-extended if src_is_signed, zero-extended otherwise.
- alu_op[14]/[15]: quotient / remainder from the divider.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE → BUSY when EX_Valid && is_div. Latch |src1| and |src2| (raw values if unsigned) and the sign flags; count <= 0.
  - BUSY: one restoring shift-subtract step per cycle; count increments. On the step with count==31, go to DONE.
  - DONE: result stable. Go to IDLE when EX_to_ME_Valid && ME_Allow_in.
- Sign fixup (signed ops only): quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Divide by zero: quotient 0xFFFFFFFF (unsigned raw), remainder = dividend. Not trapped.
- 0x80000000 / -1 signed: quotient 0x80000000, remainder 0.
- Input contract from decode: mem_we is nonzero only for stores.
- data_sram_addr = ex_result.
- Store lanes: mem_we is 0001 (byte), 0011 (half) or 1111 (word); data_sram_we = mem_we << addr[1:0].
- Store data: wdata = {4{rkd[7:0]}} for byte, {2{rkd[15:0]}} for half, rkd for word.
- data_sram_en = EX_to_ME_Valid && ME_Allow_in && (res_from_mem || |mem_we). data_sram_we is 0 whenever en is 0.

## Timing
- Non-divide ops: result is combinational in the cycle the instruction sits in EX; EX_ReadyGo=1 that cycle.
- Divide, entry in cycle 0:
  - IDLE→BUSY at the end of cycle 0; BUSY during cycles 1–32; DONE from cycle 33.
  - EX_to_ME_Valid first rises in cycle 33. Minimum occupancy is 34 cycles.
- ME backpressure in DONE: state, result and bus are held. No re-execution.
- Back-to-back divides: the second starts in its own entry cycle. DONE→IDLE and IDLE→BUSY never overlap for one instruction.
- The SRAM request is issued in the handoff cycle only, exactly once per instruction.
- Reset values:
  - EX_Valid=0, div_state=IDLE, count=0, pipeline register 0.
  - Outputs: EX_Allow_in=1, EX_to_ME_Valid=0, EX_dest=0, EX_to_ID_Ld_op=0, data_sram_en=0, data_sram_we=0.
- Reset mid-divide: abort at the next edge; nothing reaches ME.
- Reset during handoff: the request is dropped; reset wins.
- No flush input; branches resolve in decode.

## Test plan
- addi src1=5, imm=−3, ME_Allow_in=1 → same cycle: ex_result=2, EX_to_ME_Valid=1, EX_dest=rd, data_sram_en=0.
- mulh_w 0x80000000 × 2 signed → 0xFFFFFFFF; mulh_wu with the same operands → 0x00000001.
- div_w −7 / 2 → quotient 0xFFFFFFFD, mod_w → 0xFFFFFFFF. EX_to_ME_Valid low for cycles 0–32, high in cycle 33; EX_to_ID_Ld_op high for cycles 0–32.
- div_wu 10 / 0 → 0xFFFFFFFF; mod_wu 10 / 0 → 10. Then hold ME_Allow_in=0 for 5 cycles in DONE → result stable, EX_Allow_in=0, single handoff.
- st_b with addr 0x1003, rkd=0xAB → data_sram_we=1000, wdata=0xABABABAB, en pulses once. st_h at 0x1002 → we=1100.
- Assert reset in cycle 10 of a divide → cycle 11: EX_Valid=0, FSM IDLE; the next add issues normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: latches the decode bus and computes ALU, multiply and iterative divide results.
// It also issues data-SRAM requests and returns forwarding/stall info to decode.

module alu (
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  always_comb begin
    alu_result = '0;
    if      (alu_op[0])  alu_result = alu_src1 + alu_src2;
    else if (alu_op[1])  alu_result = alu_src1 - alu_src2;
    else if (alu_op[2])  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
    else if (alu_op[3])  alu_result = {31'd0, alu_src1 < alu_src2};
    else if (alu_op[4])  alu_result = alu_src1 & alu_src2;
    else if (alu_op[5])  alu_result = ~(alu_src1 | alu_src2);
    else if (alu_op[6])  alu_result = alu_src1 | alu_src2;
    else if (alu_op[7])  alu_result = alu_src1 ^ alu_src2;
    else if (alu_op[8])  alu_result = alu_src1 << alu_src2[4:0];
    else if (alu_op[9])  alu_result = alu_src1 >> alu_src2[4:0];
    else if (alu_op[10]) alu_result = $signed(alu_src1) >>> alu_src2[4:0];
    else if (alu_op[11]) alu_result = alu_src2;
  end
endmodule

module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ID_to_EX_Valid,
  input  logic [160:0] ID_to_EX_Bus,
  output logic         EX_Allow_in,
  input  logic         ME_Allow_in,
  output logic         EX_to_ME_Valid,
  output logic [74:0]  EX_to_ME_Bus,
  output logic [4:0]   EX_dest,
  output logic [31:0]  EX_Forward_Res,
  output logic         EX_to_ID_Ld_op,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic         ex_valid;
  logic [160:0] ex_bus;
  logic         ex_ready_go;

  logic         mem_is_byte, mem_is_half, src_is_signed;
  logic [15:0]  alu_op;
  logic [31:0]  pc, imm, rj_value, rkd_value;
  logic         src1_is_pc, src2_is_imm, res_from_mem, gr_we;
  logic [3:0]   mem_we;
  logic [4:0]   dest;

  assign mem_is_byte   = ex_bus[160];
  assign mem_is_half   = ex_bus[159];
  assign src_is_signed = ex_bus[158];
  assign alu_op        = ex_bus[156:141];
  assign pc            = ex_bus[140:109];
  assign imm           = ex_bus[108:77];
  assign rj_value      = ex_bus[76:45];
  assign rkd_value     = ex_bus[44:13];
  assign src1_is_pc    = ex_bus[12];
  assign src2_is_imm   = ex_bus[11];
  assign res_from_mem  = ex_bus[10];
  assign gr_we         = ex_bus[9];
  assign mem_we        = ex_bus[8:5];
  assign dest          = ex_bus[4:0];

  logic [31:0] src1, src2;
  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : rkd_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_bus   <= '0;
    end else if (EX_Allow_in) begin
      ex_valid <= ID_to_EX_Valid;
      if (ID_to_EX_Valid) ex_bus <= ID_to_EX_Bus;
    end
  end

  logic [31:0] alu_result;
  alu u_alu (
    .alu_op     (alu_op[11:0]),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  // Sign- or zero-extend to 64 bits; the low 64 product bits are then exact for both mul and mulh.
  logic [63:0] mul_a, mul_b, mul_prod;
  assign mul_a    = {{32{src_is_signed & src1[31]}}, src1};
  assign mul_b    = {{32{src_is_signed & src2[31]}}, src2};
  assign mul_prod = mul_a * mul_b;

  // Divider
  div_state_t  div_state, div_next;
  logic [4:0]  div_count;
  logic [31:0] div_q, div_r, div_b;
  logic        div_neg_q, div_neg_r, div_by_zero;
  logic        is_div;
  logic [32:0] div_shift, div_diff;
  logic [31:0] src1_mag, src2_mag;
  logic [31:0] div_quot, div_rem;

  assign is_div    = alu_op[14] | alu_op[15];
  assign src1_mag  = (src_is_signed && src1[31]) ? -src1 : src1;
  assign src2_mag  = (src_is_signed && src2[31]) ? -src2 : src2;
  assign div_shift = {div_r, div_q[31]};
  assign div_diff  = div_shift - {1'b0, div_b};

  always_ff @(posedge clk) begin
    if (reset) div_state <= DIV_IDLE;
    else       div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (ex_valid && is_div)              div_next = DIV_BUSY;
      DIV_BUSY: if (div_count == 5'd31)              div_next = DIV_DONE;
      DIV_DONE: if (EX_to_ME_Valid && ME_Allow_in)   div_next = DIV_IDLE;
      default:                                       div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_count   <= '0;
      div_q       <= '0;
      div_r       <= '0;
      div_b       <= '0;
      div_neg_q   <= 1'b0;
      div_neg_r   <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (div_state == DIV_IDLE && ex_valid && is_div) begin
      div_count   <= '0;
      div_q       <= src1_mag;
      div_r       <= '0;
      div_b       <= src2_mag;
      div_neg_q   <= src_is_signed & (src1[31] ^ src2[31]);
      div_neg_r   <= src_is_signed & src1[31];
      div_by_zero <= (src2 == 32'd0);
    end else if (div_state == DIV_BUSY) begin
      div_count <= div_count + 5'd1;
      if (!div_diff[32]) begin
        div_r <= div_diff[31:0];
        div_q <= {div_q[30:0], 1'b1};
      end else begin
        div_r <= div_shift[31:0];
        div_q <= {div_q[30:0], 1'b0};
      end
    end
  end

  assign div_quot = div_by_zero ? '1 : (div_neg_q ? -div_q : div_q);
  assign div_rem  = div_neg_r ? -div_r : div_r;

  logic [31:0] ex_result;
  always_comb begin
    ex_result = alu_result;
    if      (alu_op[12]) ex_result = mul_prod[31:0];
    else if (alu_op[13]) ex_result = mul_prod[63:32];
    else if (alu_op[14]) ex_result = div_quot;
    else if (alu_op[15]) ex_result = div_rem;
  end

  // Handshake and outputs
  always_comb begin
    ex_ready_go    = !is_div || (div_state == DIV_DONE);
    EX_Allow_in    = !ex_valid || (ex_ready_go && ME_Allow_in);
    EX_to_ME_Valid = ex_valid && ex_ready_go;
    EX_to_ID_Ld_op = ex_valid && (res_from_mem || (is_div && div_state != DIV_DONE));
    EX_dest        = (ex_valid && gr_we) ? dest : 5'd0;
    EX_Forward_Res = ex_result;
    EX_to_ME_Bus   = {ex_bus[160:157], res_from_mem, gr_we, dest, pc, ex_result};
    data_sram_en   = !reset && EX_to_ME_Valid && ME_Allow_in && (res_from_mem || (|mem_we));
    data_sram_addr = ex_result;
    data_sram_we   = data_sram_en ? (mem_we << ex_result[1:0]) : 4'd0;
    if (mem_is_byte)      data_sram_wdata = {4{rkd_value[7:0]}};
    else if (mem_is_half) data_sram_wdata = {2{rkd_value[15:0]}};
    else                  data_sram_wdata = rkd_value;
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU, multiply, divider timing, stores and reset.

module tb_ex_stage;
  logic         clk = 1'b0;
  logic         reset;
  logic         ID_to_EX_Valid;
  logic [160:0] ID_to_EX_Bus;
  logic         EX_Allow_in;
  logic         ME_Allow_in;
  logic         EX_to_ME_Valid;
  logic [74:0]  EX_to_ME_Bus;
  logic [4:0]   EX_dest;
  logic [31:0]  EX_Forward_Res;
  logic         EX_to_ID_Ld_op;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int total = 0;
  int bad   = 0;

  localparam int unsigned OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_NOR = 5,
                          OP_SRA = 10, OP_LUI = 11, OP_MUL = 12, OP_MULH = 13,
                          OP_DIV = 14, OP_MOD = 15;
  localparam logic [31:0] PC = 32'h1c00_0040;

  ex_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ID_to_EX_Valid  (ID_to_EX_Valid),
    .ID_to_EX_Bus    (ID_to_EX_Bus),
    .EX_Allow_in     (EX_Allow_in),
    .ME_Allow_in     (ME_Allow_in),
    .EX_to_ME_Valid  (EX_to_ME_Valid),
    .EX_to_ME_Bus    (EX_to_ME_Bus),
    .EX_dest         (EX_dest),
    .EX_Forward_Res  (EX_Forward_Res),
    .EX_to_ID_Ld_op  (EX_to_ID_Ld_op),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [160:0] mk(input int unsigned op, input logic [31:0] rj,
                                      input logic [31:0] rkd, input logic [31:0] imm,
                                      input logic s2imm, input logic sgn, input logic gwe,
                                      input logic rfm, input logic [3:0] mwe,
                                      input logic byt, input logic half, input logic [4:0] dst);
    logic [160:0] b;
    b = '0;
    b[160] = byt;  b[159] = half;  b[158] = sgn;
    b[141 + op] = 1'b1;
    b[140:109] = PC;  b[108:77] = imm;  b[76:45] = rj;  b[44:13] = rkd;
    b[11] = s2imm;  b[10] = rfm;  b[9] = gwe;  b[8:5] = mwe;  b[4:0] = dst;
    return b;
  endfunction

  // Loads one instruction at the next edge; returns in its cycle 0 (#1 after the edge).
  task automatic present(input logic [160:0] b);
    ID_to_EX_Bus   = b;
    ID_to_EX_Valid = 1'b1;
    @(posedge clk); #1;
    ID_to_EX_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (EX_to_ME_Valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; ID_to_EX_Valid = 1'b0; ID_to_EX_Bus = '0; ME_Allow_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (EX_Allow_in !== 1'b1)    begin bad++; $display("FAIL rst_allow got=%b exp=1", EX_Allow_in); end
    total++; if (EX_to_ME_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", EX_to_ME_Valid); end
    total++; if (EX_dest !== 5'd0)        begin bad++; $display("FAIL rst_dest got=%0d exp=0", EX_dest); end
    total++; if (EX_to_ID_Ld_op !== 1'b0) begin bad++; $display("FAIL rst_ldop got=%b exp=0", EX_to_ID_Ld_op); end
    total++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'd0)
      begin bad++; $display("FAIL rst_sram got en=%b we=%b exp en=0 we=0000", data_sram_en, data_sram_we); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi;
    present(mk(OP_ADD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1, 0, 1, 0, 4'd0, 0, 0, 5'd7));
    total++; if (EX_Forward_Res !== 32'd2) begin bad++; $display("FAIL addi_res got=%h exp=2", EX_Forward_Res); end
    total++; if (EX_to_ME_Valid !== 1'b1)  begin bad++; $display("FAIL addi_valid got=%b exp=1", EX_to_ME_Valid); end
    total++; if (EX_dest !== 5'd7)         begin bad++; $display("FAIL addi_dest got=%0d exp=7", EX_dest); end
    total++; if (data_sram_en !== 1'b0)    begin bad++; $display("FAIL addi_en got=%b exp=0", data_sram_en); end
    total++; if (EX_to_ME_Bus !== {4'b0000, 1'b0, 1'b1, 5'd7, PC, 32'd2})
      begin bad++; $display("FAIL addi_bus got=%h exp=%h", EX_to_ME_Bus, {4'b0000, 1'b0, 1'b1, 5'd7, PC, 32'd2}); end
  endtask

  task automatic test_alu_mul;
    int unsigned ops [8] = '{OP_SUB, OP_SLT, OP_SLTU, OP_NOR, OP_SRA, OP_LUI, OP_MUL, OP_MUL};
    logic [31:0] a   [8] = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 32'd0, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] b   [8] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'h1234_5000, 32'd7, 32'd2};
    logic [31:0] exp [8] = '{32'hFFFF_FFFE, 32'd1, 32'd1, 32'hFFFF_FFFF, 32'hF800_0000,
                             32'h1234_5000, 32'd21, 32'hFFFF_FFFE};
    for (int i = 0; i < 8; i++) begin
      present(mk(ops[i], a[i], b[i], 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd3));
      total++; if (EX_Forward_Res !== exp[i])
        begin bad++; $display("FAIL alu_vec%0d got=%h exp=%h", i, EX_Forward_Res, exp[i]); end
    end
    present(mk(OP_MULH, 32'h8000_0000, 32'd2, 32'd0, 0, 1, 1, 0, 4'd0, 0, 0, 5'd3));
    total++; if (EX_Forward_Res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_w got=%h exp=ffffffff", EX_Forward_Res); end
    present(mk(OP_MULH, 32'h8000_0000, 32'd2, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd3));
    total++; if (EX_Forward_Res !== 32'd1) begin bad++; $display("FAIL mulh_wu got=%h exp=00000001", EX_Forward_Res); end
  endtask

  task automatic test_div_timing;
    int errs;
    for (int k = 0; k < 2; k++) begin
      present(mk(k == 0 ? OP_DIV : OP_MOD, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 1, 1, 0, 4'd0, 0, 0, 5'd9));
      errs = 0;
      for (int c = 0; c < 33; c++) begin
        if (EX_to_ME_Valid !== 1'b0 || EX_to_ID_Ld_op !== 1'b1 || EX_Allow_in !== 1'b0) errs++;
        @(posedge clk); #1;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL div_busy_cycles got=%0d bad cycles exp=0", errs); end
      total++; if (EX_to_ME_Valid !== 1'b1 || EX_to_ID_Ld_op !== 1'b0)
        begin bad++; $display("FAIL div_c33 got valid=%b ldop=%b exp valid=1 ldop=0", EX_to_ME_Valid, EX_to_ID_Ld_op); end
      total++; if (EX_Forward_Res !== (k == 0 ? 32'hFFFF_FFFD : 32'hFFFF_FFFF))
        begin bad++; $display("FAIL div_w_res%0d got=%h exp=%h", k, EX_Forward_Res, k == 0 ? 32'hFFFF_FFFD : 32'hFFFF_FFFF); end
      @(posedge clk); #1;
      total++; if (EX_to_ME_Valid !== 1'b0) begin bad++; $display("FAIL div_after got=%b exp=0", EX_to_ME_Valid); end
    end
  endtask

  task automatic test_div_zero;
    int n, errs, hs;
    present(mk(OP_DIV, 32'd10, 32'd0, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd4));
    wait_valid(n);
    total++; if (n !== 33) begin bad++; $display("FAIL divz_lat got=%0d exp=33", n); end
    total++; if (EX_Forward_Res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_wu_z got=%h exp=ffffffff", EX_Forward_Res); end
    @(posedge clk); #1;
    ME_Allow_in = 1'b0;
    present(mk(OP_MOD, 32'd10, 32'd0, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd4));
    wait_valid(n);
    errs = 0; hs = 0;
    for (int c = 0; c < 5; c++) begin
      if (EX_to_ME_Valid !== 1'b1 || EX_Allow_in !== 1'b0 || EX_Forward_Res !== 32'd10) errs++;
      if (EX_to_ME_Valid && ME_Allow_in) hs++;
      @(posedge clk); #1;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL mod_wu_hold got=%0d bad cycles exp=0", errs); end
    ME_Allow_in = 1'b1; #1;
    if (EX_to_ME_Valid && ME_Allow_in) hs++;
    total++; if (EX_Forward_Res !== 32'd10) begin bad++; $display("FAIL mod_wu_z got=%h exp=0000000a", EX_Forward_Res); end
    @(posedge clk); #1;
    if (EX_to_ME_Valid && ME_Allow_in) hs++;
    @(posedge clk); #1;
    if (EX_to_ME_Valid && ME_Allow_in) hs++;
    total++; if (hs !== 1) begin bad++; $display("FAIL mod_wu_handoffs got=%0d exp=1", hs); end
  endtask

  task automatic test_back_to_back;
    int n;
    present(mk(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 1, 0, 4'd0, 0, 0, 5'd5));
    ID_to_EX_Bus   = mk(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, 1, 0, 4'd0, 0, 0, 5'd6);
    ID_to_EX_Valid = 1'b1;
    wait_valid(n);
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_lat1 got=%0d exp=33", n); end
    total++; if (EX_Forward_Res !== 32'h8000_0000) begin bad++; $display("FAIL div_ovf got=%h exp=80000000", EX_Forward_Res); end
    @(posedge clk); #1;
    ID_to_EX_Valid = 1'b0;
    total++; if (EX_to_ME_Valid !== 1'b0 || EX_dest !== 5'd6 || EX_to_ID_Ld_op !== 1'b1)
      begin bad++; $display("FAIL b2b_entry got valid=%b dest=%0d ldop=%b exp valid=0 dest=6 ldop=1", EX_to_ME_Valid, EX_dest, EX_to_ID_Ld_op); end
    wait_valid(n);
    total++; if (n !== 33) begin bad++; $display("FAIL b2b_lat2 got=%0d exp=33", n); end
    total++; if (EX_Forward_Res !== 32'd0) begin bad++; $display("FAIL mod_ovf got=%h exp=0", EX_Forward_Res); end
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    int pulses;
    ME_Allow_in = 1'b0;
    present(mk(OP_ADD, 32'h0000_1000, 32'h0000_00AB, 32'd3, 1, 0, 0, 0, 4'b0001, 1, 0, 5'd0));
    total++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'd0)
      begin bad++; $display("FAIL stb_stall got en=%b we=%b exp en=0 we=0000", data_sram_en, data_sram_we); end
    ME_Allow_in = 1'b1; #1;
    pulses = 0;
    if (data_sram_en) pulses++;
    total++; if (data_sram_we !== 4'b1000 || data_sram_wdata !== 32'hABAB_ABAB || data_sram_addr !== 32'h1003)
      begin bad++; $display("FAIL stb got we=%b wdata=%h addr=%h exp we=1000 wdata=abababab addr=00001003", data_sram_we, data_sram_wdata, data_sram_addr); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (data_sram_en) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL stb_pulses got=%0d exp=1", pulses); end
    present(mk(OP_ADD, 32'h0000_1000, 32'h1234_ABCD, 32'd2, 1, 0, 0, 0, 4'b0011, 0, 1, 5'd0));
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'b1100 || data_sram_wdata !== 32'hABCD_ABCD)
      begin bad++; $display("FAIL sth got en=%b we=%b wdata=%h exp en=1 we=1100 wdata=abcdabcd", data_sram_en, data_sram_we, data_sram_wdata); end
    present(mk(OP_ADD, 32'h0000_2000, 32'd0, 32'd4, 1, 1, 1, 1, 4'b0000, 0, 0, 5'd8));
    total++; if (data_sram_en !== 1'b1 || data_sram_we !== 4'd0 || EX_to_ID_Ld_op !== 1'b1)
      begin bad++; $display("FAIL ldw got en=%b we=%b ldop=%b exp en=1 we=0000 ldop=1", data_sram_en, data_sram_we, EX_to_ID_Ld_op); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    present(mk(OP_DIV, 32'd100, 32'd7, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd2));
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (EX_to_ME_Valid !== 1'b0 || EX_Allow_in !== 1'b1 || EX_to_ID_Ld_op !== 1'b0 || EX_dest !== 5'd0)
      begin bad++; $display("FAIL rst_mid got valid=%b allow=%b ldop=%b dest=%0d exp 0 1 0 0", EX_to_ME_Valid, EX_Allow_in, EX_to_ID_Ld_op, EX_dest); end
    reset = 1'b0;
    present(mk(OP_ADD, 32'd40, 32'd2, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd1));
    total++; if (EX_to_ME_Valid !== 1'b1 || EX_Forward_Res !== 32'd42)
      begin bad++; $display("FAIL rst_add got valid=%b res=%h exp valid=1 res=2a", EX_to_ME_Valid, EX_Forward_Res); end
    present(mk(OP_DIV, 32'd100, 32'd7, 32'd0, 0, 0, 1, 0, 4'd0, 0, 0, 5'd2));
    wait_valid(n);
    total++; if (n !== 33 || EX_Forward_Res !== 32'd14)
      begin bad++; $display("FAIL rst_div got lat=%0d res=%h exp lat=33 res=e", n, EX_Forward_Res); end
    @(posedge clk); #1;
    present(mk(OP_ADD, 32'h0000_1000, 32'd5, 32'd0, 1, 0, 0, 0, 4'b1111, 0, 0, 5'd0));
    reset = 1'b1; #1;
    total++; if (data_sram_en !== 1'b0 || data_sram_we !== 4'd0)
      begin bad++; $display("FAIL rst_handoff got en=%b we=%b exp en=0 we=0000", data_sram_en, data_sram_we); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_addi;
    test_alu_mul;
    test_div_timing;
    test_div_zero;
    test_back_to_back;
    test_store;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
